// File: rtl/arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin stream arbiter
// and any later schedulers built on the same priority pick.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority pick: the first set bit of i_valid,
// searching from i_ptr upwards and wrapping past N_REQ-1 to 0.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [ID_W-1:0]  o_pick,
  output logic             o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // One extra bit on the sum so ptr+k can be wrapped without overflow.
  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && i_valid[w_idx]) begin
        o_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/round_robin_stream_arbiter.sv
// N-way packet-aware round-robin arbiter: a winner owns the shared stream
// until its last beat is accepted; the data path is purely combinational.
module round_robin_stream_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ-1:0]        in_last,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready
);

  arb_state_t      r_state, w_state_nxt;
  logic [ID_W-1:0] r_ptr, w_ptr_nxt;
  logic [ID_W-1:0] r_owner, w_owner_nxt;
  logic [ID_W-1:0] w_pick;
  logic [ID_W-1:0] w_gid;
  logic            w_any;
  logic            w_xfer;
  logic [DATA_W-1:0] w_data_arr [N_REQ];

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_valid (in_valid),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_any   (w_any)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_data
    assign w_data_arr[g] = in_data[g*DATA_W +: DATA_W];
  end

  // Output mux: the owner is frozen while locked, otherwise the live pick.
  assign w_gid     = rst ? '0 : ((r_state == LOCKED) ? r_owner : w_pick);
  assign out_valid = !rst && ((r_state == LOCKED) ? in_valid[w_gid] : w_any);
  assign out_last  = in_last[w_gid];
  assign out_data  = w_data_arr[w_gid];
  assign out_id    = w_gid;
  assign w_xfer    = out_valid && out_ready;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_xfer && (w_gid == ID_W'(i))) in_ready[i] = 1'b1;
    end
  end

  // A stalled pick locks too, so out_data cannot change under a stall.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (out_valid) begin
          if (out_ready && out_last) begin
            w_ptr_nxt = ID_W'(rr_next(int'(w_gid), N_REQ));
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_pick;
          end
        end
      end
      LOCKED: begin
        if (w_xfer && out_last) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = ID_W'(rr_next(int'(r_owner), N_REQ));
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_stream_arbiter.sv
// Bench for round_robin_stream_arbiter: directed scenarios plus a randomized
// run compared against a packet-level round-robin reference model.
module tb_round_robin_stream_arbiter;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int IW     = 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic          out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who currently owns a packet (-1: nobody) and which
  // requester has top priority for the next decision.
  int m_owner = -1;
  int m_ptr   = 0;

  round_robin_stream_arbiter #(
    .N_REQ  (N),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic int ref_grant();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    m_owner = -1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'b1000;
    in_last = 4'b1000;
    in_data = 32'h44332211;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (in_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
    n_checks++;
    if (out_id !== 2'd0) begin n_errors++; $display("FAIL reset_out_id got=%0d want=0", out_id); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_id !== 2'd3) begin
      n_errors++; $display("FAIL reset_release got valid=%b id=%0d want valid=1 id=3", out_valid, out_id);
    end
    n_checks++;
    if (out_data !== 8'h44) begin n_errors++; $display("FAIL reset_release_data got=%h want=44", out_data); end
    tick();
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    do_reset();
    in_valid = 4'b1111;
    in_last = 4'b1111;
    in_data = 32'hD3C2B1A0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (out_id !== exp_id[c][1:0] || out_valid !== 1'b1) begin
        n_errors++; $display("FAIL rr_id[%0d] got id=%0d valid=%b want id=%0d valid=1", c, out_id, out_valid, exp_id[c]);
      end
      n_checks++;
      if (in_ready !== (4'b0001 << exp_id[c])) begin
        n_errors++; $display("FAIL rr_ready[%0d] got=%b want=%b", c, in_ready, 4'b0001 << exp_id[c]);
      end
      tick();
    end
  endtask

  task automatic test_packet_lock();
    logic [3:0] lasts [3] = '{4'b0000, 4'b0000, 4'b0010};
    do_reset();
    in_valid = 4'b0110;
    in_data = 32'h00CC1100;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_last = lasts[b];
      in_data[15:8] = 8'h10 + 8'(b);
      #1;
      n_checks++;
      if (out_id !== 2'd1 || in_ready !== 4'b0010) begin
        n_errors++; $display("FAIL lock_beat%0d got id=%0d ready=%b want id=1 ready=0010", b, out_id, in_ready);
      end
      n_checks++;
      if (out_data !== 8'h10 + 8'(b) || out_last !== lasts[b][1]) begin
        n_errors++; $display("FAIL lock_data%0d got data=%h last=%b want data=%h last=%b",
                             b, out_data, out_last, 8'h10 + 8'(b), lasts[b][1]);
      end
      tick();
    end
    in_valid = 4'b0100;
    in_last = 4'b0100;
    #1;
    n_checks++;
    if (out_id !== 2'd2 || in_ready !== 4'b0100 || out_data !== 8'hCC) begin
      n_errors++; $display("FAIL lock_next got id=%0d ready=%b data=%h want id=2 ready=0100 data=cc", out_id, in_ready, out_data);
    end
    tick();
  endtask

  task automatic test_stall_freeze();
    do_reset();
    in_valid = 4'b0100;
    in_last = 4'b0100;
    in_data = 32'h00A50077;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_id !== 2'd2 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
      n_errors++; $display("FAIL stall_first got id=%0d valid=%b ready=%b want id=2 valid=1 ready=0000", out_id, out_valid, in_ready);
    end
    tick();
    in_valid = 4'b0101;
    in_last = 4'b0101;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (out_id !== 2'd2 || out_data !== 8'hA5) begin
        n_errors++; $display("FAIL stall_hold%0d got id=%0d data=%h want id=2 data=a5", c, out_id, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_id !== 2'd2 || in_ready !== 4'b0100) begin
      n_errors++; $display("FAIL stall_release got id=%0d ready=%b want id=2 ready=0100", out_id, in_ready);
    end
    tick();
    in_valid = 4'b0001;
    #1;
    n_checks++;
    if (out_id !== 2'd0 || in_ready !== 4'b0001 || out_data !== 8'h77) begin
      n_errors++; $display("FAIL stall_after got id=%0d ready=%b data=%h want id=0 ready=0001 data=77", out_id, in_ready, out_data);
    end
    tick();
  endtask

  task automatic test_owner_bubble();
    do_reset();
    in_valid = 4'b0011;
    in_last = 4'b0000;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_id !== 2'd0 || in_ready !== 4'b0001) begin
      n_errors++; $display("FAIL bubble_start got id=%0d ready=%b want id=0 ready=0001", out_id, in_ready);
    end
    tick();
    in_valid = 4'b0010;
    in_last = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
        n_errors++; $display("FAIL bubble_gap%0d got valid=%b ready=%b want valid=0 ready=0000", c, out_valid, in_ready);
      end
      tick();
    end
    in_valid = 4'b0011;
    in_last = 4'b0011;
    #1;
    n_checks++;
    if (out_id !== 2'd0 || out_valid !== 1'b1 || in_ready !== 4'b0001) begin
      n_errors++; $display("FAIL bubble_resume got id=%0d valid=%b ready=%b want id=0 valid=1 ready=0001", out_id, out_valid, in_ready);
    end
    tick();
    in_valid = 4'b0010;
    #1;
    n_checks++;
    if (out_id !== 2'd1 || in_ready !== 4'b0010) begin
      n_errors++; $display("FAIL bubble_next got id=%0d ready=%b want id=1 ready=0010", out_id, in_ready);
    end
    tick();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    in_valid = 4'b0100;
    in_last = 4'b1111;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_id !== 2'd2) begin n_errors++; $display("FAIL wrap_setup got id=%0d want=2", out_id); end
    tick();
    in_valid = 4'b0110;
    #1;
    n_checks++;
    if (out_id !== 2'd1 || in_ready !== 4'b0010) begin
      n_errors++; $display("FAIL wrap_skip got id=%0d ready=%b want id=1 ready=0010", out_id, in_ready);
    end
    tick();
    #1;
    n_checks++;
    if (out_id !== 2'd2 || in_ready !== 4'b0100) begin
      n_errors++; $display("FAIL wrap_next got id=%0d ready=%b want id=2 ready=0100", out_id, in_ready);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 4'b1000;
    in_last = 4'b0000;
    out_ready = 1'b1;
    #1;
    tick();
    n_checks++;
    if (out_id !== 2'd3 || in_ready !== 4'b1000) begin
      n_errors++; $display("FAIL areset_beat2 got id=%0d ready=%b want id=3 ready=1000", out_id, in_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      n_errors++; $display("FAIL areset_immediate got valid=%b ready=%b want valid=0 ready=0000", out_valid, in_ready);
    end
    tick();
    rst = 1'b0;
    in_valid = 4'b1001;
    in_last = 4'b1001;
    #1;
    n_checks++;
    if (out_id !== 2'd0 || in_ready !== 4'b0001) begin
      n_errors++; $display("FAIL areset_after got id=%0d ready=%b want id=0 ready=0001", out_id, in_ready);
    end
    tick();
  endtask

  task automatic test_random();
    int g;
    logic ev;
    logic [3:0] er;
    logic [N*DW-1:0] dsnap;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      in_last = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = $urandom();
      #1;
      g = ref_grant();
      ev = (m_owner >= 0) ? in_valid[g] : (in_valid != 4'b0000);
      er = (ev && out_ready) ? (4'b0001 << g) : 4'b0000;
      dsnap = in_data;
      n_checks++;
      if (out_valid !== ev || out_id !== 2'(g) || in_ready !== er) begin
        n_errors++; $display("FAIL rand[%0d] got valid=%b id=%0d ready=%b want valid=%b id=%0d ready=%b",
                             c, out_valid, out_id, in_ready, ev, g, er);
      end
      if (ev) begin
        n_checks++;
        if (out_data !== dsnap[g*DW +: DW] || out_last !== in_last[g]) begin
          n_errors++; $display("FAIL rand_data[%0d] got data=%h last=%b want data=%h last=%b",
                               c, out_data, out_last, dsnap[g*DW +: DW], in_last[g]);
        end
        if (out_ready && in_last[g]) begin
          m_owner = -1;
          m_ptr = (g + 1) % N;
        end else if (m_owner < 0) begin
          m_owner = g;
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_stall_freeze();
    test_owner_bubble();
    test_wrap_skip();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
